load_store_queue: RTL and testbench
===================================

# load_store_queue

Load/store queue feeding the compute unit's data-memory path; the responder end of the controller's LSU handshake. Accepts LD/ST requests via `queue_write_en`/`instr_bit` and buffers them in order in a circular FIFO. Models a fixed memory latency per head entry, then pulses `done_bit` with `instr_bit_out`, so the controller raises `mem_read_en`/`reg_write_en` (LD) or `mem_write_en` (ST) for exactly that cycle.

## Interface
- `DEPTH`, 8: queue entries, power of two, ≥2.
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 16: store data width.
- `REG_W`, 4: thread register index width.
- `MEM_LATENCY`, 2: wait cycles per access, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `queue_write_en` in 1: enqueue request.
- `instr_bit` in 1: 0 = LD, 1 = ST.
- `addr_in` in ADDR_W: access address.
- `data_in` in DATA_W: store data (don't-care for LD).
- `rd_in` in REG_W: LD destination register (don't-care for ST).
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out $clog2(DEPTH+1): occupancy.
- `done_bit` out 1: head access completes this cycle.
- `instr_bit_out` out 1: head entry type.
- `mem_addr` out ADDR_W: head address.
- `mem_wdata` out DATA_W: head store data.
- `reg_waddr` out REG_W: head LD destination.
- `overflow` out 1: sticky dropped-request flag (only with macro).

## Operation
- Entry = {is_store, addr, data, rd}; head/tail pointers log2(DEPTH) bits, natural wrap.
- Accept: `queue_write_en && (!full || pop)`, where pop = (state == DONE). Enqueue while full and not popping is dropped, with no state change.
- FSM states:
  - IDLE: `!empty` -> WAIT, cnt = MEM_LATENCY-1.
  - WAIT: cnt == 0 -> DONE, else cnt--.
  - DONE: pop head. If entries remain after the pop, including one accepted this edge, go to WAIT with cnt = MEM_LATENCY-1; otherwise go to IDLE.
- `done_bit` = (state == DONE), decoded from the state register.
- `instr_bit_out`, `mem_addr`, `mem_wdata`, `reg_waddr` present head fields while `!empty`; all zero when empty.
- Ordering is strict FIFO; no reordering or forwarding between LD and ST.

## Timing
- Reset values: count 0, empty 1, full 0, done_bit 0, instr_bit_out 0, mem_addr/mem_wdata/reg_waddr 0, overflow 0, state IDLE, pointers 0.
- Enqueue at edge E into an empty, IDLE queue:
  - `empty` falls after E.
  - `done_bit` is high for exactly one cycle, starting after edge E+MEM_LATENCY+1.
  - Pop occurs at the following edge.
- Throughput: one completion per MEM_LATENCY+1 cycles when back-to-back.
- Head outputs are stable from WAIT entry through DONE.
- Simultaneous enqueue and pop: count unchanged. When full, the enqueue is accepted.
- `reset` asserted mid-WAIT or mid-DONE discards all entries at that edge. `done_bit` is low the next cycle and no memory enable follows.

## Configuration
- `LSQ_OVERFLOW_FLAG_EN` defined:
  - `overflow` sets on any dropped enqueue.
  - It holds until `reset`.
- Undefined:
  - The `overflow` port is absent.
  - Drops are silent.

## Test plan
- Reset, then single LD {addr 0x10, rd 3} at edge 0 with MEM_LATENCY 2 -> done_bit high in cycle 3 only, instr_bit_out 0, mem_addr 0x10, reg_waddr 3; empty = 1 after edge 4.
- ST {0x20, data 0xBEEF} then LD {0x21, rd 5} on consecutive edges -> first done: instr_bit_out 1, mem_wdata 0xBEEF; second done exactly 3 cycles later: instr_bit_out 0, mem_addr 0x21.
- Enqueue 9 requests into DEPTH 8 with no pops -> full = 1, count 8, 9th dropped; with macro, overflow = 1. Drain -> 8 done pulses in original order.
- Full queue, enqueue on the DONE cycle -> accepted; count stays 8 and the new entry completes last.
- Reset asserted during WAIT with 3 entries queued -> count 0, empty 1, no done_bit within the next 10 cycles.
- Wrap: 20 requests enqueued and drained with occupancy ≤3 -> all addresses are returned in order across the pointer wrap.

Source files
------------

// File: rtl/load_store_queue.sv
// load_store_queue: in-order LD/ST request FIFO with a fixed per-access
// memory latency. Each head entry waits MEM_LATENCY cycles, then done_bit
// pulses for one cycle while the head fields are presented, and the entry
// is popped on the following edge.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   queue_write_en        - enqueue request (dropped when full and not popping)
//   instr_bit             - request type: 0 = LD, 1 = ST
//   addr_in/data_in/rd_in - request address, store data, LD destination register
//   full/empty/count      - occupancy status
//   done_bit              - head access completes this cycle
//   instr_bit_out, mem_addr, mem_wdata, reg_waddr
//                         - head entry fields, all zero while empty
//   overflow              - sticky dropped-request flag (LSQ_OVERFLOW_FLAG_EN only)
//
// Optional feature macro: LSQ_OVERFLOW_FLAG_EN
module load_store_queue #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REG_W       = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         queue_write_en,
    input  logic                         instr_bit,
    input  logic [ADDR_W-1:0]            addr_in,
    input  logic [DATA_W-1:0]            data_in,
    input  logic [REG_W-1:0]             rd_in,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done_bit,
    output logic                         instr_bit_out,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [REG_W-1:0]             reg_waddr
`ifdef LSQ_OVERFLOW_FLAG_EN
    ,
    output logic                         overflow
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(MEM_LATENCY - 1);

    typedef struct packed {
        logic              is_store;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [LAT_W-1:0] cnt_q;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           head_entry;
    logic             pop;
    logic             accept;

    // Occupancy status straight from the count register
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Pop happens on the edge that ends the DONE cycle; a full queue still
    // accepts on that edge because the head slot is being freed.
    always_comb begin
        pop     = (state_q == S_DONE);
        accept  = queue_write_en && (!full || pop);
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        head_d  = pop    ? head_q + PTR_W'(1) : head_q;
        tail_d  = accept ? tail_q + PTR_W'(1) : tail_q;
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[tail_q] <= '{is_store: instr_bit, addr: addr_in, data: data_in, rd: rd_in};
        end
    end

    // Pointers, occupancy and the latency FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        state_q <= S_WAIT;
                        cnt_q   <= LAT_RELOAD;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end
                end
                S_DONE: begin
                    // Chain straight into the next access, counting any
                    // entry accepted on this same edge.
                    if (count_d != '0) begin
                        state_q <= S_WAIT;
                        cnt_q   <= LAT_RELOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done_bit   = (state_q == S_DONE);
    assign head_entry = mem_q[head_q];

    // Head fields are masked to zero while the queue is empty
    always_comb begin
        instr_bit_out = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        reg_waddr     = '0;
        if (!empty) begin
            instr_bit_out = head_entry.is_store;
            mem_addr      = head_entry.addr;
            mem_wdata     = head_entry.data;
            reg_waddr     = head_entry.rd;
        end
    end

`ifdef LSQ_OVERFLOW_FLAG_EN
    logic overflow_q;

    // Sticky record of any enqueue lost to a full queue
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (queue_write_en && !accept) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        queue_write_en = 1'b0;
    logic        instr_bit = 1'b0;
    logic [7:0]  addr_in = '0;
    logic [15:0] data_in = '0;
    logic [3:0]  rd_in = '0;
    logic        full, empty, done_bit, instr_bit_out;
    logic [3:0]  count;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [3:0]  reg_waddr;
`ifdef LSQ_OVERFLOW_FLAG_EN
    logic        overflow;
`endif

    load_store_queue #(
        .DEPTH(8), .ADDR_W(8), .DATA_W(16), .REG_W(4), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .queue_write_en(queue_write_en),
        .instr_bit(instr_bit), .addr_in(addr_in), .data_in(data_in), .rd_in(rd_in),
        .full(full), .empty(empty), .count(count), .done_bit(done_bit),
        .instr_bit_out(instr_bit_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_waddr(reg_waddr)
`ifdef LSQ_OVERFLOW_FLAG_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    // Expected request with the cycle (edge index) after which it completes
    typedef struct {
        logic        st;
        logic [7:0]  a;
        logic [15:0] dt;
        logic [3:0]  r;
        int          dn;
    } ent_t;

    ent_t pending[$];   // model queue contents, popped at the pop edge
    ent_t exp_q[$];     // scoreboard, popped by the monitor at completion
    int   m_t = -1;     // index of the most recent edge
    int   m_count = 0;
    int   last_d = -100;
    bit   m_ovf = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, m_t, act, req);
        end
    endtask

    // Drive one edge worth of inputs and advance the reference model
    task automatic step(input logic rst, input logic we, input logic st,
                        input logic [7:0] a, input logic [15:0] dt, input logic [3:0] r);
        int  t;
        bit  pop, acc;
        ent_t e;
        @(negedge clk);
        #1;
        reset = rst; queue_write_en = we; instr_bit = st;
        addr_in = a; data_in = dt; rd_in = r;
        t = m_t + 1;
        if (rst) begin
            pending.delete();
            exp_q.delete();
            last_d = -100;
            m_ovf = 1'b0;
        end else begin
            pop = (pending.size() > 0) && (pending[0].dn + 1 == t);
            acc = we && ((pending.size() < DEPTH) || pop);
            if (we && !acc) m_ovf = 1'b1;
            if (pop) void'(pending.pop_front());
            if (acc) begin
                // A request enqueued no later than the previous entry's pop
                // edge starts its wait right at that pop; otherwise it idles
                // one cycle before waiting.
                e.st = st; e.a = a; e.dt = dt; e.r = r;
                e.dn = (t <= last_d + 1) ? last_d + LAT + 1 : t + LAT + 1;
                last_d = e.dn;
                pending.push_back(e);
                exp_q.push_back(e);
            end
        end
        m_count = pending.size();
        m_t = t;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 4'h0);
    endtask

    task automatic enq(input logic st, input logic [7:0] a, input logic [15:0] dt, input logic [3:0] r);
        step(1'b0, 1'b1, st, a, dt, r);
    endtask

    ent_t h;
    bit   expd;

    // Monitor: compare status every cycle and retire completions in order
    always @(negedge clk) begin
        if (m_t >= 0) begin
            h = '{st: 1'b0, a: 8'h0, dt: 16'h0, r: 4'h0, dn: -1};
            if (exp_q.size() > 0) h = exp_q[0];
            expd = (exp_q.size() > 0) && (exp_q[0].dn == m_t);
            chk("count", int'(count), m_count);
            chk("empty", int'(empty), int'(m_count == 0));
            chk("full", int'(full), int'(m_count == DEPTH));
            chk("done_bit", int'(done_bit), int'(expd));
            chk("instr_bit_out", int'(instr_bit_out), int'(h.st));
            chk("mem_addr", int'(mem_addr), int'(h.a));
            chk("mem_wdata", int'(mem_wdata), int'(h.dt));
            chk("reg_waddr", int'(reg_waddr), int'(h.r));
`ifdef LSQ_OVERFLOW_FLAG_EN
            chk("overflow", int'(overflow), int'(m_ovf));
`endif
            if ((exp_q.size() > 0) && (exp_q[0].dn <= m_t)) void'(exp_q.pop_front());
        end
    end

    initial begin
        int guard;
        // Reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h0, 16'h0, 4'h0);

        // Single LD
        enq(1'b0, 8'h10, 16'h0, 4'd3);
        idle(8);

        // ST then LD on consecutive edges
        enq(1'b1, 8'h20, 16'hBEEF, 4'd0);
        enq(1'b0, 8'h21, 16'h0, 4'd5);
        idle(10);

        // Back-to-back enqueues: fills the queue, drops, accepts on DONE while full
        for (int i = 0; i < 24; i++)
            enq(1'($urandom), 8'(i + 8'h40), 16'($urandom), 4'($urandom));
        idle(40);

        // Reset while waiting with three entries queued
        for (int i = 0; i < 3; i++) enq(1'b0, 8'(8'h80 + i), 16'h0, 4'(i));
        idle(2);
        step(1'b1, 1'b0, 1'b0, 8'h0, 16'h0, 4'h0);
        idle(12);

        // Pointer wrap with low occupancy
        for (int i = 0; i < 20; i++) begin
            enq(1'($urandom), 8'(8'hA0 + i), 16'($urandom), 4'($urandom));
            idle(2);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 9) < 6),
                 1'($urandom), 8'($urandom), 16'($urandom), 4'($urandom));
        end

        // Drain with a bounded wait
        guard = 0;
        while ((exp_q.size() > 0) && (guard < 100)) begin
            idle(1);
            guard++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
